// File: rtl/clock_divider_bank.sv
// clock_divider_bank: N_CH toggle-style slow clocks from Fast_Clock, each with a runtime divisor double-buffered to the toggle boundary.
// Latency: Slow_Clock/Tick/Pending are registered and change together on the edge where count reaches the active divisor.
// Backpressure: none; writes always land (out-of-range Wr_Ch ignored). Macro CLKDIV_PHASE_SYNC_EN adds the Sync phase-align input.
module clock_divider_bank #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2500
) (
  input  logic             Fast_Clock,
  input  logic             Reset,
  input  logic [N_CH-1:0]  Enable,
  input  logic             Wr_En,
  input  logic [3:0]       Wr_Ch,
  input  logic [CNT_W-1:0] Wr_Data,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic             Sync,
`endif
  output logic [N_CH-1:0]  Slow_Clock,
  output logic [N_CH-1:0]  Tick,
  output logic [N_CH-1:0]  Pending
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  // Per-channel state: running count, divisor in use, and the staged divisor.
  logic [CNT_W-1:0] count  [N_CH];
  logic [CNT_W-1:0] active [N_CH];
  logic [CNT_W-1:0] shadow [N_CH];

  logic [N_CH-1:0] wr_hit;
  logic [N_CH-1:0] toggle_now;
  logic            sync_req;

`ifdef CLKDIV_PHASE_SYNC_EN
  assign sync_req = Sync;
`else
  // Without the phase-sync option every channel free-runs from its reset phase.
  assign sync_req = 1'b0;
`endif

  // Decode the write target and detect which channels end their half-period this cycle.
  always_comb begin
    wr_hit     = '0;
    toggle_now = '0;
    for (int c = 0; c < N_CH; c++) begin
      wr_hit[c]     = Wr_En && (Wr_Ch == 4'(c));
      toggle_now[c] = Enable[c] && (count[c] >= active[c]);
    end
  end

  // Counting, toggling and divisor hand-over; a write issued after the toggle
  // decision so a same-cycle write stays pending for the following boundary.
  always_ff @(posedge Fast_Clock) begin
    if (Reset) begin
      for (int c = 0; c < N_CH; c++) begin
        count[c]      <= '0;
        active[c]     <= DEF_DIV;
        shadow[c]     <= DEF_DIV;
        Slow_Clock[c] <= 1'b1;
        Tick[c]       <= 1'b0;
        Pending[c]    <= 1'b0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (sync_req) begin
          count[c]      <= '0;
          Slow_Clock[c] <= 1'b1;
          Tick[c]       <= 1'b0;
          active[c]     <= shadow[c];
          Pending[c]    <= 1'b0;
        end else if (toggle_now[c]) begin
          count[c]      <= '0;
          Slow_Clock[c] <= ~Slow_Clock[c];
          Tick[c]       <= 1'b1;
          active[c]     <= shadow[c];
          Pending[c]    <= 1'b0;
        end else begin
          Tick[c] <= 1'b0;
          if (Enable[c]) begin
            count[c] <= count[c] + CNT_W'(1);
          end
        end
        if (wr_hit[c]) begin
          shadow[c]  <= Wr_Data;
          Pending[c] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// tb_clock_divider_bank: vector table, directed corner sequences and random traffic for clock_divider_bank.
// Latency: outputs sampled 1 time unit after each rising edge and compared against a cycle-level reference.
// Backpressure: not applicable; every cycle is driven and checked.
module tb_clock_divider_bank;

  localparam int N = 4;
  localparam int DIV0 = 3;

  logic        Fast_Clock;
  logic        Reset;
  logic [3:0]  Enable;
  logic        Wr_En;
  logic [3:0]  Wr_Ch;
  logic [15:0] Wr_Data;
  logic [3:0]  Slow_Clock;
  logic [3:0]  Tick;
  logic [3:0]  Pending;
`ifdef CLKDIV_PHASE_SYNC_EN
  logic        sync_in;
`endif

  int total;
  int bad;

  clock_divider_bank #(.N_CH(N), .CNT_W(16), .DEFAULT_DIV(DIV0)) dut (
    .Fast_Clock(Fast_Clock),
    .Reset(Reset),
    .Enable(Enable),
    .Wr_En(Wr_En),
    .Wr_Ch(Wr_Ch),
    .Wr_Data(Wr_Data),
`ifdef CLKDIV_PHASE_SYNC_EN
    .Sync(sync_in),
`endif
    .Slow_Clock(Slow_Clock),
    .Tick(Tick),
    .Pending(Pending)
  );

  initial Fast_Clock = 1'b0;
  always #5 Fast_Clock = ~Fast_Clock;

  // Reference: each channel tracks how many enabled cycles it has spent in the
  // current half-period; the half-period lasts (divisor + 1) such cycles.
  int m_elapsed [N];
  int m_act     [N];
  int m_sh      [N];
  bit m_slow    [N];
  bit m_tick    [N];
  bit m_pend    [N];

  function automatic void model_update(input logic r, input logic [3:0] en,
                                       input logic we, input logic [3:0] ch,
                                       input logic [15:0] d);
    bit s;
    s = 1'b0;
`ifdef CLKDIV_PHASE_SYNC_EN
    s = sync_in;
`endif
    for (int c = 0; c < N; c++) begin
      if (r) begin
        m_elapsed[c] = 0; m_act[c] = DIV0; m_sh[c] = DIV0;
        m_slow[c] = 1'b1; m_tick[c] = 1'b0; m_pend[c] = 1'b0;
        continue;
      end
      m_tick[c] = 1'b0;
      if (s) begin
        m_elapsed[c] = 0; m_slow[c] = 1'b1; m_act[c] = m_sh[c]; m_pend[c] = 1'b0;
      end else if (en[c]) begin
        m_elapsed[c] = m_elapsed[c] + 1;
        if (m_elapsed[c] == m_act[c] + 1) begin
          m_elapsed[c] = 0; m_slow[c] = !m_slow[c]; m_tick[c] = 1'b1;
          m_act[c] = m_sh[c]; m_pend[c] = 1'b0;
        end
      end
      if (we && int'(ch) == c) begin
        m_sh[c] = int'(d); m_pend[c] = 1'b1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the reference at the edge, compare after it.
  task automatic step(input logic r, input logic [3:0] en, input logic we,
                      input logic [3:0] ch, input logic [15:0] d);
    logic [3:0] es, et, ep;
    Reset = r; Enable = en; Wr_En = we; Wr_Ch = ch; Wr_Data = d;
    @(posedge Fast_Clock);
    model_update(r, en, we, ch, d);
    #1;
    for (int c = 0; c < N; c++) begin
      es[c] = m_slow[c]; et[c] = m_tick[c]; ep[c] = m_pend[c];
    end
    check("model_slow", 16'(Slow_Clock), 16'(es));
    check("model_tick", 16'(Tick), 16'(et));
    check("model_pend", 16'(Pending), 16'(ep));
  endtask

  task automatic cycles_to_tick(input int ch, input logic [3:0] en, output int n);
    n = 0;
    do begin
      step(1'b0, en, 1'b0, 4'd0, 16'd0);
      n++;
    end while (!Tick[ch] && n < 50);
    if (!Tick[ch]) begin
      total++; bad++;
      $display("FAIL tick_timeout ch=%0d got=none exp=tick within 50", ch);
    end
  endtask

  typedef struct {
    logic rst; logic [3:0] en; logic we; logic [3:0] ch; logic [15:0] d;
    logic [3:0] slow; logic [3:0] tick; logic [3:0] pend;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] en, input logic we,
                              input logic [3:0] ch, input logic [15:0] d,
                              input logic [3:0] slow, input logic [3:0] tick,
                              input logic [3:0] pend);
    vec_t v;
    v.rst = rst; v.en = en; v.we = we; v.ch = ch; v.d = d;
    v.slow = slow; v.tick = tick; v.pend = pend;
    vecs.push_back(v);
  endfunction

  initial begin
    int n;
    total = 0; bad = 0;
    Reset = 1'b1; Enable = '0; Wr_En = 1'b0; Wr_Ch = '0; Wr_Data = '0;
`ifdef CLKDIV_PHASE_SYNC_EN
    sync_in = 1'b0;
`endif
    for (int c = 0; c < N; c++) begin
      m_elapsed[c] = 0; m_act[c] = DIV0; m_sh[c] = DIV0;
      m_slow[c] = 1; m_tick[c] = 0; m_pend[c] = 0;
    end

    // Reset state, then DIV=3: 4 high, 4 low, 4 high, ticks every 4th cycle.
    add(1, 4'h0, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'hF, 4'hF, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'hF, 4'h0, 4'h0);
    add(0, 4'hF, 0, 0, 0, 4'h0, 4'hF, 4'h0);
    add(0, 4'hF, 1, 9, 1, 4'h0, 4'h0, 4'h0);   // out-of-range channel: ignored
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].ch, vecs[i].d);
      check("vec_slow", 16'(Slow_Clock), 16'(vecs[i].slow));
      check("vec_tick", 16'(Tick), 16'(vecs[i].tick));
      check("vec_pend", 16'(Pending), 16'(vecs[i].pend));
    end

    // ch1 <- 0 written at count 1: pending until its toggle, then every-cycle toggling.
    step(0, 4'hF, 1, 1, 0);
    check("wr1_pend", 16'(Pending), 16'h2);
    step(0, 4'hF, 0, 0, 0);
    check("wr1_pend_hold", 16'(Pending), 16'h2);
    step(0, 4'hF, 0, 0, 0);
    check("wr1_tog_tick", 16'(Tick), 16'hF);
    check("wr1_tog_pend", 16'(Pending), 16'h0);
    step(0, 4'hF, 0, 0, 0);
    check("div0_tick_a", 16'(Tick), 16'h2);
    check("div0_slow_a", 16'(Slow_Clock), 16'hD);
    step(0, 4'hF, 0, 0, 0);
    check("div0_tick_b", 16'(Tick), 16'h2);
    check("div0_slow_b", 16'(Slow_Clock), 16'hF);

    // ch2 <- 7 in its toggle cycle: next half-period 4, the one after 8.
    for (int k = 0; k < 20 && m_elapsed[2] != m_act[2]; k++) step(0, 4'hF, 0, 0, 0);
    step(0, 4'hF, 1, 2, 7);
    check("wr2_coinc_tick", 16'(Tick[2]), 16'h1);
    check("wr2_coinc_pend", 16'(Pending[2]), 16'h1);
    cycles_to_tick(2, 4'hF, n);
    check("wr2_half_old", 16'(n), 16'd4);
    check("wr2_pend_clear", 16'(Pending[2]), 16'h0);
    cycles_to_tick(2, 4'hF, n);
    check("wr2_half_new", 16'(n), 16'd8);

    // Hold ch0 for 5 cycles at count 2; it resumes and toggles 2 cycles later.
    for (int k = 0; k < 20 && m_elapsed[0] != 2; k++) step(0, 4'hF, 0, 0, 0);
    begin
      bit held;
      held = m_slow[0];
      for (int k = 0; k < 5; k++) begin
        step(0, 4'hE, 0, 0, 0);
        check("dis_tick", 16'(Tick[0]), 16'h0);
        check("dis_slow", 16'(Slow_Clock[0]), 16'(held));
      end
      step(0, 4'hF, 0, 0, 0);
      check("reen_tick_a", 16'(Tick[0]), 16'h0);
      step(0, 4'hF, 0, 0, 0);
      check("reen_tick_b", 16'(Tick[0]), 16'h1);
      check("reen_slow", 16'(Slow_Clock[0]), 16'(!held));
    end

    // Reset mid-period with a pending write and a same-cycle write: reset wins.
    step(0, 4'hF, 1, 3, 5);
    check("wr3_pend", 16'(Pending[3]), 16'h1);
    step(1, 4'hF, 1, 0, 9);
    check("rst_slow", 16'(Slow_Clock), 16'hF);
    check("rst_tick", 16'(Tick), 16'h0);
    check("rst_pend", 16'(Pending), 16'h0);
    for (int k = 0; k < 3; k++) begin
      step(0, 4'hF, 1, 9, 0);
      check("post_rst_tick", 16'(Tick), 16'h0);
      check("post_rst_pend", 16'(Pending), 16'h0);
    end
    step(0, 4'hF, 0, 0, 0);
    check("post_rst_div", 16'(Tick), 16'hF);

`ifdef CLKDIV_PHASE_SYNC_EN
    // Sync with ch0 divisor 1, ch1 divisor 3: ch0 ticks 2 cycles later, ch1 4.
    step(0, 4'hF, 1, 0, 1);
    step(0, 4'hF, 1, 1, 3);
    for (int k = 0; k < int'($urandom_range(1, 7)); k++) step(0, 4'hF, 0, 0, 0);
    sync_in = 1'b1;
    step(0, 4'hF, 0, 0, 0);
    sync_in = 1'b0;
    check("sync_slow", 16'(Slow_Clock[1:0]), 16'h3);
    check("sync_pend", 16'(Pending), 16'h0);
    step(0, 4'hF, 0, 0, 0);
    check("sync_t1", 16'(Tick[1:0]), 16'h0);
    step(0, 4'hF, 0, 0, 0);
    check("sync_t2", 16'(Tick[1:0]), 16'h1);
    step(0, 4'hF, 0, 0, 0);
    check("sync_t3", 16'(Tick[1:0]), 16'h0);
    step(0, 4'hF, 0, 0, 0);
    check("sync_t4", 16'(Tick[1:0]), 16'h3);
`endif

    // Random enables, writes (including out-of-range channels) and rare resets.
    for (int k = 0; k < 400; k++) begin
`ifdef CLKDIV_PHASE_SYNC_EN
      sync_in = ($urandom_range(0, 31) == 0);
`endif
      step(($urandom_range(0, 63) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 5)),
           16'($urandom_range(0, 5)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
